fifo_drain_ctrl: RTL and testbench
==================================

Name: fifo_drain_ctrl

Overview:
- Read-side (drain) sequencer for the 8-longword DMA FIFO, memory-to-SCSI direction.
- Moves each 32-bit FIFO entry to the 8-bit SCSI controller as 4 byte transfers using the DREQ_/DACK_ handshake.
- Pulses DECFIFO once per fully drained longword; the FIFO full/empty counter consumes it, and its FIFOEMPTY flag is an input here.
- Owns the FIFO read pointer and the byte-lane select driving the FIFO output mux.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth in longwords; RD_PTR width.
- STROBE_CYC, 2, CLK cycles SWE_ is held low per byte (legal range 1..7).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_FIFO_  in  1  asynchronous, active-low reset (also the FIFO reset).
- EN  in  1  drain enable; DMA active and direction is memory-to-SCSI.
- FIFOEMPTY  in  1  from full/empty counter; 1 = no longword available.
- DREQ_  in  1  SCSI controller data request, active-low, asynchronous to CLK.
- DACK_  out  1  DMA acknowledge to SCSI controller, active-low.
- SWE_  out  1  write strobe into SCSI data register, active-low.
- BYTE_SEL  out  2  byte lane of current longword (0 = bits 31:24 ... 3 = bits 7:0).
- RD_PTR  out  DEPTH_LOG2  FIFO read address.
- DECFIFO  out  1  one-CLK pulse: one longword consumed.
- BUSY  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset: RST_FIFO_ low asynchronously forces the following. The abort is immediate, even mid-strobe.
  - state=IDLE, RD_PTR=0, BYTE_SEL=0.
  - DACK_=1, SWE_=1, DECFIFO=0, BUSY=0.
  - DREQ_ sync flops=1 (inactive).
- DREQ_ passes through a 2-flop synchroniser; dreq_s = synchronised active-high request; 2-cycle latency.
- FSM states IDLE, SETUP, STROBE, HOLD, ADVANCE; all outputs are registered.
  - IDLE: DACK_=1, SWE_=1. Go to SETUP when EN & ~FIFOEMPTY & dreq_s; otherwise stay.
  - SETUP (1 cycle): DACK_=0, SWE_=1. Data on BYTE_SEL settles.
  - STROBE (STROBE_CYC cycles, counted by a 3-bit down-counter): DACK_=0, SWE_=0.
  - HOLD (1 cycle): DACK_=0, SWE_=1. Data held after the rising strobe.
  - ADVANCE (1 cycle): DACK_=1.
    - BYTE_SEL <= BYTE_SEL+1 (wraps 3->0).
    - If BYTE_SEL was 3: DECFIFO=1 for exactly this cycle, RD_PTR <= RD_PTR+1 mod 2^DEPTH_LOG2.
    - Always returns to IDLE.
- Byte time: 4+STROBE_CYC cycles including IDLE (6 at default).
- DECFIFO is always followed by at least 1 low cycle, so each pulse is a distinct edge for the counter.
- FIFOEMPTY is sampled only in IDLE. It stays 0 while lanes 0-2 of a word drain because DECFIFO has not fired yet.
- EN or DREQ_ deasserted mid-byte: the current byte completes through ADVANCE, then the FSM holds in IDLE. BYTE_SEL and RD_PTR are retained; the partial word resumes at the retained lane.
- FIFOEMPTY rising mid-byte (illegal upstream): ignored until the next IDLE.
- No path drives DECFIFO while FIFOEMPTY=1 in IDLE.

Optional Feature:
- Macro: FIFO_DRAIN_FLUSH_EN.
- Defined: adds input FLUSH (active-high, synchronous).
  - Sampled in IDLE when BYTE_SEL!=0 and EN=1: the residue of the partial word is discarded. DECFIFO pulses 1 cycle, RD_PTR increments, BYTE_SEL <= 0, state stays IDLE.
  - FLUSH has priority over starting a transfer.
  - FLUSH with BYTE_SEL=0 has no effect.
- Undefined: port absent; partial words persist until drained or reset.

Decomposition:
- Package sdmac_fifo_pkg holds:
  - FSM state enum (drain_state_t).
  - FIFO_DEPTH_LOG2=3.
  - BYTES_PER_WORD=4.
  - Byte-lane constants.
- One sub-module: sdmac_sync2, a generic 2-flop synchroniser with a reset value port. It is used for DREQ_ and is reusable elsewhere.

Test Plan:
- Reset during STROBE (SWE_=0) -> SWE_=1, DACK_=1 immediately (no CLK); RD_PTR=0, BYTE_SEL=0, BUSY=0.
- EN=1, FIFOEMPTY=0, DREQ_=0 held, one word -> 4 SWE_ low pulses of 2 cycles each, BYTE_SEL 0,1,2,3, then a single DECFIFO pulse; RD_PTR 0->1. First SETUP occurs 3 cycles after DREQ_ falls; 24 cycles total.
- Drain 8 words back-to-back -> 8 DECFIFO pulses, each followed by a low cycle; RD_PTR 7->0 wrap; 32 strobes.
- DREQ_ released after byte 1 -> FSM parks in IDLE, BYTE_SEL=2, no DECFIFO; DREQ_ reasserted -> lanes 2,3 sent, then DECFIFO.
- FIFOEMPTY=1, EN=1, DREQ_=0 for 50 cycles -> BUSY=0, DACK_=1, no strobes; FIFOEMPTY->0 -> transfer starts next IDLE evaluation.
- FIFO_DRAIN_FLUSH_EN: FLUSH after 1 byte sent -> DECFIFO 1 cycle, RD_PTR+1, BYTE_SEL=0, no strobe.

Source files
------------

// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared types and constants for the SDMAC FIFO drain path.
// State encoding, FIFO geometry and byte-lane constants.
package sdmac_fifo_pkg;

    localparam int FIFO_DEPTH_LOG2 = 3;
    localparam int BYTES_PER_WORD  = 4;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE_FIRST = lane_t'(0);
    localparam lane_t LANE_LAST  = lane_t'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        DRAIN_IDLE,
        DRAIN_SETUP,
        DRAIN_STROBE,
        DRAIN_HOLD,
        DRAIN_ADVANCE
    } drain_state_t;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// Drain-side handshake bundle between the FIFO drain sequencer and its
// surroundings. FLUSH exists only when FIFO_DRAIN_FLUSH_EN is defined.
interface fifo_drain_ctrl_if #(
    parameter int DEPTH_LOG2 = 3
);

    logic                  EN;
    logic                  FIFOEMPTY;
    logic                  DREQ_;
    logic                  DACK_;
    logic                  SWE_;
    logic [1:0]            BYTE_SEL;
    logic [DEPTH_LOG2-1:0] RD_PTR;
    logic                  DECFIFO;
    logic                  BUSY;
`ifdef FIFO_DRAIN_FLUSH_EN
    logic                  FLUSH;

    modport master (
        input  EN, FIFOEMPTY, DREQ_, FLUSH,
        output DACK_, SWE_, BYTE_SEL, RD_PTR, DECFIFO, BUSY
    );

    modport slave (
        output EN, FIFOEMPTY, DREQ_, FLUSH,
        input  DACK_, SWE_, BYTE_SEL, RD_PTR, DECFIFO, BUSY
    );
`else
    modport master (
        input  EN, FIFOEMPTY, DREQ_,
        output DACK_, SWE_, BYTE_SEL, RD_PTR, DECFIFO, BUSY
    );

    modport slave (
        output EN, FIFOEMPTY, DREQ_,
        input  DACK_, SWE_, BYTE_SEL, RD_PTR, DECFIFO, BUSY
    );
`endif

endinterface

// File: rtl/sdmac_sync2.sv
// Generic two-flop synchroniser with a per-instance reset value.
// Used for the asynchronous SCSI DREQ_ and reusable for other inputs.
module sdmac_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; reset parks both stages at the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// FIFO drain sequencer: sends each longword to the SCSI chip as 4 bytes.
// Optional macro FIFO_DRAIN_FLUSH_EN adds FLUSH to drop a partial word.
module fifo_drain_ctrl
    import sdmac_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
    parameter int STROBE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST_FIFO_,
    fifo_drain_ctrl_if.master bus
);

    localparam logic [2:0] STROBE_LOAD = 3'(STROBE_CYC - 1);

    drain_state_t          state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    lane_t                 byte_sel_q, byte_sel_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic                  dack_q, dack_d;
    logic                  swe_q, swe_d;
    logic                  decfifo_q, decfifo_d;
    logic                  busy_q, busy_d;
    logic                  dreq_n_s;
    logic                  dreq_s;
    logic                  start_go;
    logic                  flush_go;

    sdmac_sync2 #(
        .WIDTH (1)
    ) u_dreq_sync (
        .clk     (CLK),
        .rst_n   (RST_FIFO_),
        .rst_val (1'b1),
        .d       (bus.DREQ_),
        .q       (dreq_n_s)
    );

    assign dreq_s = ~dreq_n_s;

    // A pulse still in flight means FIFOEMPTY is stale; wait one cycle.
    assign start_go = bus.EN & ~bus.FIFOEMPTY & dreq_s & ~decfifo_q;

`ifdef FIFO_DRAIN_FLUSH_EN
    assign flush_go = bus.FLUSH & bus.EN & (byte_sel_q != LANE_FIRST);
`else
    assign flush_go = 1'b0;
`endif

    // Next-state, lane/pointer advance and registered output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_sel_d = byte_sel_q;
        rd_ptr_d   = rd_ptr_q;
        decfifo_d  = 1'b0;
        unique case (state_q)
            DRAIN_IDLE: begin
                if (flush_go) begin
                    decfifo_d  = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    byte_sel_d = LANE_FIRST;
                end else if (start_go) begin
                    state_d = DRAIN_SETUP;
                end
            end
            DRAIN_SETUP: begin
                state_d = DRAIN_STROBE;
                cnt_d   = STROBE_LOAD;
            end
            DRAIN_STROBE: begin
                if (cnt_q == 3'd0) begin
                    state_d = DRAIN_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DRAIN_HOLD: begin
                state_d    = DRAIN_ADVANCE;
                byte_sel_d = byte_sel_q + 2'd1;
                if (byte_sel_q == LANE_LAST) begin
                    decfifo_d = 1'b1;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                end
            end
            DRAIN_ADVANCE: begin
                state_d = DRAIN_IDLE;
            end
            default: begin
                state_d = DRAIN_IDLE;
            end
        endcase
        dack_d = ~((state_d == DRAIN_SETUP) ||
                   (state_d == DRAIN_STROBE) ||
                   (state_d == DRAIN_HOLD));
        swe_d  = (state_d != DRAIN_STROBE);
        busy_d = (state_d != DRAIN_IDLE);
    end

    // State and output registers; reset aborts any byte in progress.
    always_ff @(posedge CLK or negedge RST_FIFO_) begin
        if (!RST_FIFO_) begin
            state_q    <= DRAIN_IDLE;
            cnt_q      <= 3'd0;
            byte_sel_q <= LANE_FIRST;
            rd_ptr_q   <= '0;
            dack_q     <= 1'b1;
            swe_q      <= 1'b1;
            decfifo_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_sel_q <= byte_sel_d;
            rd_ptr_q   <= rd_ptr_d;
            dack_q     <= dack_d;
            swe_q      <= swe_d;
            decfifo_q  <= decfifo_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.DACK_    = dack_q;
    assign bus.SWE_     = swe_q;
    assign bus.BYTE_SEL = byte_sel_q;
    assign bus.RD_PTR   = rd_ptr_q;
    assign bus.DECFIFO  = decfifo_q;
    assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: cycle trace table, directed
// corner cases and a randomized run against a word/byte-level model.
module tb_fifo_drain_ctrl;

    localparam int SC = 2;
    localparam int DL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic dreq_n = 1'b1;
    logic empty_force = 1'b1;
    logic flush = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    bit model_on = 1'b0;
    bit add_on = 1'b0;
    bit mon_on = 1'b0;
    int words_avail = 0;
    int supplied = 0;

    int strobe_n = 0;
    int dec_n = 0;
    int low_cnt = 0;
    bit prev_swe = 1'b1;
    bit prev_dec = 1'b0;

    always #5 clk = ~clk;

    fifo_drain_ctrl_if #(.DEPTH_LOG2(DL)) bus ();

    assign bus.EN        = en;
    assign bus.DREQ_     = dreq_n;
    assign bus.FIFOEMPTY = model_on ? (words_avail == 0) : empty_force;
`ifdef FIFO_DRAIN_FLUSH_EN
    assign bus.FLUSH     = flush;
`endif

    fifo_drain_ctrl #(
        .DEPTH_LOG2 (DL),
        .STROBE_CYC (SC)
    ) dut (
        .CLK       (clk),
        .RST_FIFO_ (rst_n),
        .bus       (bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        dreq_n = 1'b1;
        empty_force = 1'b1;
        flush = 1'b0;
        model_on = 1'b0;
        add_on = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // FIFO occupancy model: consumes one word per DECFIFO, random refills.
    always @(posedge clk) begin : fifo_model
        int na;
        if (!model_on) begin
            words_avail <= 0;
            supplied <= 0;
        end else begin
            na = words_avail - (bus.DECFIFO ? 1 : 0);
            if (add_on && na < 8 && $urandom_range(0, 3) == 0) begin
                na = na + 1;
                supplied <= supplied + 1;
            end
            words_avail <= na;
        end
    end

    // Byte stream scoreboard: k-th strobe carries lane k%4 of word k/4.
    always @(negedge clk) begin
        if (!rst_n || !mon_on) begin
            strobe_n <= 0;
            dec_n <= 0;
            low_cnt <= 0;
            prev_swe <= 1'b1;
            prev_dec <= 1'b0;
        end else begin
            if (!bus.SWE_) begin
                if (prev_swe) begin
                    check("strobe_lane", bus.BYTE_SEL, strobe_n % 4);
                    check("strobe_rd_ptr", bus.RD_PTR, (strobe_n / 4) % 8);
                    check("strobe_dack", bus.DACK_, 0);
                    if (model_on)
                        check("strobe_word_avail", (strobe_n / 4) < supplied, 1);
                    strobe_n <= strobe_n + 1;
                    low_cnt <= 1;
                end else begin
                    low_cnt <= low_cnt + 1;
                end
            end else if (!prev_swe) begin
                check("swe_width", low_cnt, SC);
            end
            if (bus.DECFIFO) begin
                check("dec_gap", prev_dec, 0);
                check("dec_after_4_bytes", strobe_n, 4 * (dec_n + 1));
                dec_n <= dec_n + 1;
            end
            prev_swe <= bus.SWE_;
            prev_dec <= bus.DECFIFO;
        end
    end

    typedef struct {
        int         k;
        logic [8:0] exp;
    } vec_t;

    function automatic logic [8:0] pk(bit d, bit s, bit c, bit b,
                                      int bs, int rp);
        return {d, s, c, b, 2'(bs), 3'(rp)};
    endfunction

    vec_t vecs[15];

    initial begin
        int cur;
        int bad;
        int seen;
        bit found;
        bit done;

        // cycle k = sample after k-th rising edge since DREQ_ fell
        // fields: DACK_, SWE_, DECFIFO, BUSY, BYTE_SEL, RD_PTR
        vecs[0]  = '{1,  pk(1, 1, 0, 0, 0, 0)};
        vecs[1]  = '{2,  pk(1, 1, 0, 0, 0, 0)};
        vecs[2]  = '{3,  pk(0, 1, 0, 1, 0, 0)};
        vecs[3]  = '{4,  pk(0, 0, 0, 1, 0, 0)};
        vecs[4]  = '{5,  pk(0, 0, 0, 1, 0, 0)};
        vecs[5]  = '{6,  pk(0, 1, 0, 1, 0, 0)};
        vecs[6]  = '{7,  pk(1, 1, 0, 1, 1, 0)};
        vecs[7]  = '{8,  pk(1, 1, 0, 0, 1, 0)};
        vecs[8]  = '{9,  pk(0, 1, 0, 1, 1, 0)};
        vecs[9]  = '{19, pk(1, 1, 0, 1, 3, 0)};
        vecs[10] = '{21, pk(0, 1, 0, 1, 3, 0)};
        vecs[11] = '{22, pk(0, 0, 0, 1, 3, 0)};
        vecs[12] = '{25, pk(1, 1, 1, 1, 0, 1)};
        vecs[13] = '{26, pk(1, 1, 0, 0, 0, 1)};
        vecs[14] = '{27, pk(1, 1, 0, 0, 0, 1)};

        mon_on = 1'b1;
        do_reset();

        check("reset_outputs",
              {bus.DACK_, bus.SWE_, bus.DECFIFO, bus.BUSY,
               bus.BYTE_SEL, bus.RD_PTR},
              pk(1, 1, 0, 0, 0, 0));

        // single word, cycle-accurate trace
        en = 1'b1;
        empty_force = 1'b0;
        dreq_n = 1'b0;
        cur = 0;
        foreach (vecs[i]) begin
            tick(vecs[i].k - cur);
            cur = vecs[i].k;
            check($sformatf("trace_k%0d", cur),
                  {bus.DACK_, bus.SWE_, bus.DECFIFO, bus.BUSY,
                   bus.BYTE_SEL, bus.RD_PTR},
                  vecs[i].exp);
            if (cur == 25) empty_force = 1'b1;
        end
        check("one_word_strobes", strobe_n, 4);
        check("one_word_decs", dec_n, 1);

        // asynchronous reset in the middle of a strobe
        empty_force = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            tick();
            if (bus.SWE_ === 1'b0) found = 1'b1;
        end
        check("midstrobe_reached", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_swe", bus.SWE_, 1);
        check("async_rst_dack", bus.DACK_, 1);
        check("async_rst_state",
              {bus.BUSY, bus.BYTE_SEL, bus.RD_PTR}, 0);
        tick();
        do_reset();

        // DREQ_ released after the second byte starts; resume later
        en = 1'b1;
        empty_force = 1'b0;
        dreq_n = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            if (bus.BYTE_SEL === 2'd1) found = 1'b1;
        end
        check("park_reach_lane1", found, 1);
        dreq_n = 1'b1;
        tick(20);
        check("park_lane", bus.BYTE_SEL, 2);
        check("park_busy", bus.BUSY, 0);
        check("park_no_dec", dec_n, 0);
        check("park_strobes", strobe_n, 2);
        dreq_n = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            tick();
            if (bus.DECFIFO === 1'b1) begin
                found = 1'b1;
                empty_force = 1'b1;
            end
        end
        check("resume_dec_seen", found, 1);
        check("resume_lane", bus.BYTE_SEL, 0);
        check("resume_rd_ptr", bus.RD_PTR, 1);
        check("resume_strobes", strobe_n, 4);

        // FIFOEMPTY held: nothing may start
        do_reset();
        en = 1'b1;
        dreq_n = 1'b0;
        bad = 0;
        repeat (50) begin
            tick();
            if (bus.BUSY !== 1'b0 || bus.DACK_ !== 1'b1 || bus.SWE_ !== 1'b1)
                bad++;
        end
        check("empty_idle_cycles_bad", bad, 0);
        check("empty_no_strobe", strobe_n, 0);
        empty_force = 1'b0;
        tick();
        check("empty_release_busy", bus.BUSY, 1);
        check("empty_release_dack", bus.DACK_, 0);

        // eight words back to back, pointer wraps
        do_reset();
        en = 1'b1;
        dreq_n = 1'b0;
        empty_force = 1'b0;
        seen = 0;
        for (int c = 0; c < 8 * 4 * 6 + 40 && seen < 8; c++) begin
            tick();
            if (bus.DECFIFO === 1'b1) begin
                seen++;
                if (seen == 8) empty_force = 1'b1;
            end
        end
        tick(5);
        check("b2b_pulses", seen, 8);
        check("b2b_dec_count", dec_n, 8);
        check("b2b_strobes", strobe_n, 32);
        check("b2b_rd_ptr_wrap", bus.RD_PTR, 0);
        check("b2b_idle", {bus.BUSY, bus.BYTE_SEL}, 0);

`ifdef FIFO_DRAIN_FLUSH_EN
        // flush the residue after one byte
        mon_on = 1'b0;
        do_reset();
        en = 1'b1;
        empty_force = 1'b0;
        dreq_n = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (bus.BUSY === 1'b1) found = 1'b1;
        end
        dreq_n = 1'b1;
        tick(15);
        check("flush_park_lane", bus.BYTE_SEL, 1);
        flush = 1'b1;
        tick();
        check("flush_pulse",
              {bus.DECFIFO, bus.SWE_, bus.BUSY, bus.BYTE_SEL, bus.RD_PTR},
              {1'b1, 1'b1, 1'b0, 2'd0, 3'd1});
        flush = 1'b0;
        tick();
        check("flush_pulse_end", bus.DECFIFO, 0);
        mon_on = 1'b1;
`endif

        // randomized traffic against the occupancy model
        do_reset();
        model_on = 1'b1;
        add_on = 1'b1;
        repeat (3000) begin
            tick();
            en = ($urandom_range(0, 7) != 0);
            dreq_n = ($urandom_range(0, 2) == 0);
        end
        add_on = 1'b0;
        en = 1'b1;
        dreq_n = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            tick();
            if (words_avail == 0 && bus.BUSY === 1'b0 && bus.BYTE_SEL === 2'd0)
                done = 1'b1;
        end
        check("rand_drained", done, 1);
        check("rand_traffic", supplied > 20, 1);
        check("rand_dec_count", dec_n, supplied);
        check("rand_strobes", strobe_n, 4 * supplied);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
